// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned BCD_W     = 8;
  localparam int unsigned LAP_TMR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button.
// press_c is a one-cycle pulse in the cycle the accepted level goes 0->1.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_c
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ_c;

  assign differ_c = (sync2_q != level_q);

  // cnt_q holds how many earlier consecutive samples already disagreed
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (differ_c) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_c = differ_c & sync2_q & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : btn_debounce

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button events, IDLE/RUN/PAUSE FSM, timebase,
// count strobes for the BCD register, lap capture/hold and display select.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 800000,
  parameter int unsigned DEBOUNCE       = 16,
  parameter int unsigned LAP_HOLD_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic [BCD_W-1:0] time_value,
  output logic             count_en,
  output logic             count_clr,
  output logic [BCD_W-1:0] display_value,
  output logic             running,
  output logic             lap_active
);

  localparam int unsigned PRESC_W = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [LAP_TMR_W-1:0] LAP_LOAD   = LAP_TMR_W'(LAP_HOLD_TICKS);

  logic start_c, stop_c, clear_c, lap_c;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_start), .press_c(start_c)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_stop (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_stop), .press_c(stop_c)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clear (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .press_c(clear_c)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_lap), .press_c(lap_c)
  );

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 count_en_q, count_en_d;
  logic                 count_clr_q, count_clr_d;
  logic                 running_q, running_d;
  logic                 lap_active_q, lap_active_d;
  logic [LAP_TMR_W-1:0] lap_tmr_q, lap_tmr_d;
  logic [BCD_W-1:0]     lap_reg_q, lap_reg_d;
  logic [BCD_W-1:0]     display_q, display_d;

  logic tick_c;
  logic clear_act_c, stop_act_c, start_act_c, lap_act_c;

  assign tick_c = (presc_q == PRESC_LAST);

  // Priority clear > stop > start > lap; an event only acts where it applies
  assign clear_act_c = clear_c;
  assign stop_act_c  = ~clear_c & stop_c & (state_q == RUN);
  assign start_act_c = ~clear_c & start_c & (state_q != RUN);
  assign lap_act_c   = ~clear_c & ~stop_act_c & lap_c & (state_q == RUN);

  always_comb begin
    state_d      = state_q;
    presc_d      = tick_c ? '0 : presc_q + PRESC_W'(1);
    count_en_d   = 1'b0;
    count_clr_d  = 1'b0;
    lap_active_d = lap_active_q;
    lap_tmr_d    = lap_tmr_q;
    lap_reg_d    = lap_reg_q;

    case (state_q)
      IDLE: begin
        if (start_act_c) state_d = RUN;
      end
      RUN: begin
        if (stop_act_c) state_d = PAUSE;
        count_en_d = tick_c & ~stop_act_c & ~clear_act_c;
      end
      PAUSE: begin
        if (start_act_c) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (clear_act_c) begin
      state_d     = IDLE;
      count_clr_d = 1'b1;
    end
    if (clear_act_c || start_act_c) presc_d = '0;

    // Lap hold: a fresh capture wins over a same-cycle tick decrement
    if (clear_act_c) begin
      lap_active_d = 1'b0;
      lap_tmr_d    = '0;
    end else if (lap_act_c) begin
      lap_reg_d    = time_value;
      lap_active_d = 1'b1;
      lap_tmr_d    = LAP_LOAD;
    end else if (tick_c && lap_active_q) begin
      lap_tmr_d = lap_tmr_q - LAP_TMR_W'(1);
      if (lap_tmr_q == LAP_TMR_W'(1)) lap_active_d = 1'b0;
    end

    running_d = (state_d == RUN);
    display_d = lap_active_q ? lap_reg_q : time_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      count_en_q   <= 1'b0;
      count_clr_q  <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_tmr_q    <= '0;
      lap_reg_q    <= '0;
      display_q    <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_en_q   <= count_en_d;
      count_clr_q  <= count_clr_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      lap_tmr_q    <= lap_tmr_d;
      lap_reg_q    <= lap_reg_d;
      display_q    <= display_d;
    end
  end

  assign count_en      = count_en_q;
  assign count_clr     = count_clr_q;
  assign running       = running_q;
  assign lap_active    = lap_active_q;
  assign display_value = display_q;

endmodule : stopwatch_ctrl
